// File: rtl/proc_pkg.sv
// Shared processor definitions: memory geometry, loader state encoding and
// instruction field layout.
package proc_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned WORD_W = 10;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StWaitLo = 2'b01,
        StWaitHi = 2'b10,
        StWrite  = 2'b11
    } ld_state_e;

    // Instruction word layout: {selector, alu_op, imm}
    localparam int unsigned SEL_MSB = 9;
    localparam int unsigned SEL_LSB = 8;
    localparam int unsigned ALU_MSB = 7;
    localparam int unsigned ALU_LSB = 4;
    localparam int unsigned IMM_MSB = 3;
    localparam int unsigned IMM_LSB = 0;

    function automatic logic [WORD_W-1:0] make_word(input logic [1:0] sel,
                                                    input logic [7:0] lo);
        return {sel, lo};
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push button -> synchronised, debounced level -> single-cycle rising-edge pulse.
// A clean press becomes a pulse DEB_CYCLES+3 cycles later.
module btn_conditioner #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk0,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            pulse_q      <= stable_q & ~stable_dly_q;
        end
    end

    // The level flips only after DEB_CYCLES consecutive samples disagree with it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/prog_loader.sv
// Program memory loader: assembles 10-bit words from two switch bytes and writes
// them at a self-incrementing address while holding the CPU.
module prog_loader
    import proc_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic              clk0,
    input  logic              rst_n,
    input  logic [7:0]        sw,
    input  logic              btn_load,
    input  logic              btn_mode,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [WORD_W-1:0] pm_wdata,
    output logic              cpu_hold,
    output logic              pc_clear,
    output logic [7:0]        status
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic load_p, mode_p;

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        lo_byte_q, lo_byte_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              full_q, full_d;
    logic              was_load_q;

    btn_conditioner #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_load_btn (
        .clk0 (clk0),
        .rst_n(rst_n),
        .btn  (btn_load),
        .pulse(load_p)
    );

    btn_conditioner #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_mode_btn (
        .clk0 (clk0),
        .rst_n(rst_n),
        .btn  (btn_mode),
        .pulse(mode_p)
    );

    // State register
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; mode beats load, and WRITE ignores both.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (mode_p) state_d = StWaitLo;
            StWaitLo: if (mode_p) state_d = StRun;
                      else if (load_p) state_d = StWaitHi;
            StWaitHi: if (mode_p) state_d = StRun;
                      else if (load_p) state_d = StWrite;
            StWrite:  state_d = (addr_q == ADDR_LAST) ? StRun : StWaitLo;
            default:  state_d = StRun;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            lo_byte_q  <= '0;
            wdata_q    <= '0;
            full_q     <= 1'b0;
            was_load_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            lo_byte_q  <= lo_byte_d;
            wdata_q    <= wdata_d;
            full_q     <= full_d;
            was_load_q <= (state_q != StRun);
        end
    end

    always_comb begin
        addr_d    = addr_q;
        lo_byte_d = lo_byte_q;
        wdata_d   = wdata_q;
        full_d    = full_q;
        if (state_q == StRun && mode_p) begin
            addr_d = '0;
        end
        if (state_q == StWaitLo && !mode_p && load_p) begin
            lo_byte_d = sw;
        end
        if (state_q == StWaitHi && !mode_p && load_p) begin
            wdata_d = make_word(sw[1:0], lo_byte_q);
        end
        if (state_q == StWrite) begin
            addr_d = addr_q + 1'b1;
            if (addr_q == ADDR_LAST) begin
                full_d = 1'b1;
            end
        end
        if (state_d == StWaitLo && state_q != StWaitLo) begin
            full_d = 1'b0;
        end
    end

    // Outputs decode registered state only, so they are glitch-free per cycle.
    always_comb begin
        cpu_hold = (state_q != StRun);
        pm_we    = (state_q == StWrite);
        pm_addr  = addr_q;
        pm_wdata = wdata_q;
        pc_clear = (state_q == StRun) && was_load_q;
        status   = {state_q, 1'b0, full_q, addr_q};
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a short debounce window.
module tb_prog_loader;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = DEB + 6;

    logic       clk0 = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       btn_load, btn_mode;
    logic       pm_we;
    logic [3:0] pm_addr;
    logic [9:0] pm_wdata;
    logic       cpu_hold, pc_clear;
    logic [7:0] status;

    int n_vec = 0;
    int n_bad = 0;

    int         we_cnt = 0;
    int         pc_cnt = 0;
    int         pc_hold_bad = 0;
    logic [3:0] last_addr = '0;
    logic [9:0] last_data = '0;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [9:0] exp_data;
    } vec_t;

    vec_t vt[16];

    prog_loader #(
        .DEB_CYCLES(DEB)
    ) dut (
        .clk0    (clk0),
        .rst_n   (rst_n),
        .sw      (sw),
        .btn_load(btn_load),
        .btn_mode(btn_mode),
        .pm_we   (pm_we),
        .pm_addr (pm_addr),
        .pm_wdata(pm_wdata),
        .cpu_hold(cpu_hold),
        .pc_clear(pc_clear),
        .status  (status)
    );

    always #5 clk0 = ~clk0;

    always @(negedge clk0) begin
        if (pm_we) begin
            we_cnt    <= we_cnt + 1;
            last_addr <= pm_addr;
            last_data <= pm_wdata;
        end
        if (pc_clear) begin
            pc_cnt <= pc_cnt + 1;
            if (cpu_hold) pc_hold_bad <= pc_hold_bad + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called and returns at posedge+1.
    task automatic press(input logic m, input logic l, input logic [7:0] v);
        sw       = v;
        btn_mode = m;
        btn_load = l;
        repeat (HOLD) @(posedge clk0);
        #1;
        btn_mode = 1'b0;
        btn_load = 1'b0;
        repeat (HOLD) @(posedge clk0);
        #1;
    endtask

    int we0, pc0;

    initial begin
        // word k = {k[1:0], k*3}; hi bytes carry junk in [7:2]
        vt[0]  = '{8'h00, 8'hB4, 10'h000};
        vt[1]  = '{8'h03, 8'hB5, 10'h103};
        vt[2]  = '{8'h06, 8'hB6, 10'h206};
        vt[3]  = '{8'h09, 8'hB7, 10'h309};
        vt[4]  = '{8'h0C, 8'hB4, 10'h00C};
        vt[5]  = '{8'h0F, 8'hB5, 10'h10F};
        vt[6]  = '{8'h12, 8'hB6, 10'h212};
        vt[7]  = '{8'h15, 8'hB7, 10'h315};
        vt[8]  = '{8'h18, 8'hB4, 10'h018};
        vt[9]  = '{8'h1B, 8'hB5, 10'h11B};
        vt[10] = '{8'h1E, 8'hB6, 10'h21E};
        vt[11] = '{8'h21, 8'hB7, 10'h321};
        vt[12] = '{8'h24, 8'hB4, 10'h024};
        vt[13] = '{8'h27, 8'hB5, 10'h127};
        vt[14] = '{8'h2A, 8'hB6, 10'h22A};
        vt[15] = '{8'h2D, 8'hB7, 10'h32D};

        rst_n = 1'b0; sw = '0; btn_load = 1'b0; btn_mode = 1'b0;
        #2;
        check("rst_pm_we",    32'(pm_we),    32'h0);
        check("rst_pm_wdata", 32'(pm_wdata), 32'h0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'h0);
        check("rst_pc_clear", 32'(pc_clear), 32'h0);
        check("rst_status",   32'(status),   32'h0);
        repeat (3) @(posedge clk0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk0);
        #1;

        // Single word A5/FE
        press(1'b1, 1'b0, 8'h00);
        press(1'b0, 1'b1, 8'hA5);
        press(1'b0, 1'b1, 8'hFE);
        check("w1_count", 32'(we_cnt),     32'd1);
        check("w1_addr",  32'(last_addr),  32'h0);
        check("w1_data",  32'(last_data),  32'h2A5);
        check("w1_state", 32'(status),     32'h41);
        check("w1_hold",  32'(cpu_hold),   32'h1);

        // Reset mid-load while a press is still being debounced
        btn_load = 1'b1;
        repeat (2) @(posedge clk0);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_we",     32'(pm_we),    32'h0);
        check("mid_rst_wdata",  32'(pm_wdata), 32'h0);
        check("mid_rst_hold",   32'(cpu_hold), 32'h0);
        check("mid_rst_pcclr",  32'(pc_clear), 32'h0);
        check("mid_rst_status", 32'(status),   32'h0);
        btn_load = 1'b0;
        @(posedge clk0);
        #1 rst_n = 1'b1;
        we0 = we_cnt;
        press(1'b0, 1'b1, 8'h11);
        press(1'b0, 1'b1, 8'h22);
        check("post_rst_no_we",  32'(we_cnt), 32'(we0));
        check("post_rst_status", 32'(status), 32'h0);
        press(1'b1, 1'b0, 8'h00);
        check("enter_load", 32'(status), 32'h40);

        // Full 16-word load with auto-finish
        we0 = we_cnt;
        pc0 = pc_cnt;
        for (int k = 0; k < 16; k++) begin
            press(1'b0, 1'b1, vt[k].lo);
            press(1'b0, 1'b1, vt[k].hi);
            check($sformatf("vec%0d_count", k), 32'(we_cnt - we0), 32'(k + 1));
            check($sformatf("vec%0d_addr", k),  32'(last_addr),    32'(k));
            check($sformatf("vec%0d_data", k),  32'(last_data),    32'(vt[k].exp_data));
        end
        check("full_status",  32'(status),         32'h10);
        check("full_hold",    32'(cpu_hold),       32'h0);
        check("full_pcclr",   32'(pc_cnt - pc0),   32'd1);
        check("pcclr_hold",   32'(pc_hold_bad),    32'd0);

        // Abort in WAIT_HI after three words
        press(1'b1, 1'b0, 8'h00);
        check("reenter_status", 32'(status), 32'h40);
        we0 = we_cnt;
        pc0 = pc_cnt;
        for (int k = 0; k < 3; k++) begin
            press(1'b0, 1'b1, vt[k + 4].lo);
            press(1'b0, 1'b1, vt[k + 4].hi);
        end
        press(1'b0, 1'b1, 8'h99);
        check("abort_pre_state", 32'(status), 32'h83);
        press(1'b1, 1'b0, 8'h00);
        check("abort_writes", 32'(we_cnt - we0),  32'd3);
        check("abort_state",  32'(status[7:6]),   32'h0);
        check("abort_hold",   32'(cpu_hold),      32'h0);
        check("abort_pcclr",  32'(pc_cnt - pc0),  32'd1);
        press(1'b1, 1'b0, 8'h00);
        check("restart_addr", 32'(status), 32'h40);

        // Bounce, then settle high: one pulse after DEB+3 cycles
        sw = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            btn_load = (i % 2 == 0);
            repeat (2) @(posedge clk0);
            #1;
        end
        check("bounce_no_pulse", 32'(status[7:6]), 32'h1);
        btn_load = 1'b1;
        repeat (DEB + 3) @(posedge clk0);
        #1;
        check("settle_early", 32'(status[7:6]), 32'h1);
        @(posedge clk0);
        #1;
        check("settle_exact", 32'(status[7:6]), 32'h2);
        repeat (20) @(posedge clk0);
        #1;
        check("hold_one_pulse", 32'(status[7:6]), 32'h2);
        btn_load = 1'b0;
        repeat (HOLD) @(posedge clk0);
        #1;
        press(1'b1, 1'b0, 8'h00);
        check("bounce_exit", 32'(status[7:6]), 32'h0);

        // Simultaneous mode and load in WAIT_LO: mode wins
        press(1'b1, 1'b0, 8'h00);
        we0 = we_cnt;
        pc0 = pc_cnt;
        press(1'b1, 1'b1, 8'h77);
        check("both_state", 32'(status[7:6]),  32'h0);
        check("both_hold",  32'(cpu_hold),     32'h0);
        check("both_no_we", 32'(we_cnt - we0), 32'd0);
        check("both_pcclr", 32'(pc_cnt - pc0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
